imm_field_encoder: RTL and testbench



---
 rtl/imm_field_encoder.sv | 122 ++++++++++++
 tb/tb_imm_field_encoder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/imm_field_encoder.sv
// RV32I immediate encoder for the instruction-injection path: scatters an immediate
// into a template word, range-checks it, and optionally expands I-type into LUI + I.
module imm_field_encoder (
  input  logic        CPU_CLK,
  input  logic        CPU_RST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_type,
  input  logic [31:0] in_imm,
  input  logic [31:0] in_base,
  input  logic        in_split,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic        out_err,
  output logic        out_last
);

  // Type codes mirror the shared Parameters.v defines.
  localparam logic [2:0] ITYPE = 3'd1;
  localparam logic [2:0] STYPE = 3'd2;
  localparam logic [2:0] BTYPE = 3'd3;
  localparam logic [2:0] UTYPE = 3'd4;
  localparam logic [2:0] JTYPE = 3'd5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    HI    = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] word2;

  logic [31:0] enc_word;
  logic        enc_err;
  logic        split_go;
  logic [19:0] hi;
  logic [31:0] lui_word;
  logic [31:0] lo_word;

  logic accept;
  logic consume;

  assign in_ready  = (state == EMPTY) || (state == ONE && out_ready);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;

  // Upper part rounds up when lo is negative, so that LUI + sign-extended lo == imm.
  assign hi       = in_imm[31:12] + {19'b0, in_imm[11]};
  assign lui_word = {hi, in_base[11:7], 7'b0110111};
  assign lo_word  = {in_base[31:20] | in_imm[11:0], in_base[11:7], in_base[14:0]};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    enc_word = in_base;
    enc_err  = 1'b0;
    split_go = 1'b0;
    case (in_type)
      ITYPE: begin
        enc_word = in_base | {in_imm[11:0], 20'b0};
        enc_err  = (in_imm[31:11] != {21{in_imm[31]}});
        split_go = in_split && enc_err;
      end
      STYPE: begin
        enc_word = in_base | {in_imm[11:5], 13'b0, in_imm[4:0], 7'b0};
        enc_err  = (in_imm[31:11] != {21{in_imm[31]}});
      end
      BTYPE: begin
        enc_word = in_base | {in_imm[12], in_imm[10:5], 13'b0, in_imm[4:1], in_imm[11], 7'b0};
        enc_err  = (in_imm[31:12] != {20{in_imm[31]}}) || in_imm[0];
      end
      UTYPE: begin
        enc_word = in_base | {in_imm[31:12], 12'b0};
        enc_err  = (in_imm[11:0] != 12'b0);
      end
      JTYPE: begin
        enc_word = in_base | {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], 12'b0};
        enc_err  = (in_imm[31:20] != {12{in_imm[31]}}) || in_imm[0];
      end
      default: begin
        enc_word = in_base;
        enc_err  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CPU_CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (CPU_RST) begin
      state    <= EMPTY;
      out_word <= 32'b0;
      out_err  <= 1'b0;
      out_last <= 1'b0;
      word2    <= 32'b0;
    end else if (accept) begin
      if (split_go) begin
        state    <= HI;
        out_word <= lui_word;
        out_err  <= 1'b0;
        out_last <= 1'b0;
        word2    <= lo_word;
      end else begin
        state    <= ONE;
        out_word <= enc_word;
        out_err  <= enc_err;
        out_last <= 1'b1;
      end
    end else if (consume) begin
      if (state == HI) begin
        state    <= ONE;
        out_word <= word2;
        out_err  <= 1'b0;
        out_last <= 1'b1;
      end else begin
        state <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_imm_field_encoder.sv
// Directed bench for imm_field_encoder: encodings, range errors, split pairs,
// streaming, backpressure and reset during a split.
module tb_imm_field_encoder;

  localparam logic [2:0] ITYPE = 3'd1;
  localparam logic [2:0] STYPE = 3'd2;
  localparam logic [2:0] BTYPE = 3'd3;
  localparam logic [2:0] UTYPE = 3'd4;
  localparam logic [2:0] JTYPE = 3'd5;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_type;
  logic [31:0] in_imm;
  logic [31:0] in_base;
  logic        in_split;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic        out_err;
  logic        out_last;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  imm_field_encoder dut (
    .CPU_CLK   (clk),
    .CPU_RST   (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_type   (in_type),
    .in_imm    (in_imm),
    .in_base   (in_base),
    .in_split  (in_split),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_err   (out_err),
    .out_last  (out_last)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fails++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] t, input logic [31:0] imm, input logic [31:0] base,
                       input logic split);
    in_valid = 1'b1;
    in_type  = t;
    in_imm   = imm;
    in_base  = base;
    in_split = split;
  endtask

  // Present one request for a single edge (caller guarantees in_ready), then idle the inputs.
  task automatic req(input logic [2:0] t, input logic [31:0] imm, input logic [31:0] base,
                     input logic split);
    drive(t, imm, base, split);
    step();
    in_valid = 1'b0;
  endtask

  task automatic expect_word(input string tag, input logic [31:0] w, input logic e, input logic l);
    check({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, ".word"},  out_word, w);
    check({tag, ".err"},   {31'b0, out_err}, {31'b0, e});
    check({tag, ".last"},  {31'b0, out_last}, {31'b0, l});
  endtask

  logic [31:0] held;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_type   = 3'd0;
    in_imm    = 32'b0;
    in_base   = 32'b0;
    in_split  = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();

    check("rst.valid", {31'b0, out_valid}, 32'd0);
    check("rst.word",  out_word, 32'd0);
    check("rst.err",   {31'b0, out_err}, 32'd0);
    check("rst.last",  {31'b0, out_last}, 32'd0);
    check("rst.ready", {31'b0, in_ready}, 32'd1);

    // Plain encodings, one cycle after accept; each next request is accepted on the consume edge.
    req(ITYPE, 32'hFFFF_FFFF, 32'h0000_0093, 1'b0);
    expect_word("i_neg1", 32'hFFF0_0093, 1'b0, 1'b1);
    req(STYPE, 32'h0000_07FC, 32'h0020_A023, 1'b0);
    expect_word("s", 32'h7E20_AE23, 1'b0, 1'b1);
    req(BTYPE, 32'hFFFF_FFFC, 32'h0000_0063, 1'b0);
    expect_word("b", 32'hFE00_0EE3, 1'b0, 1'b1);
    req(UTYPE, 32'hABCD_E000, 32'h0000_00B7, 1'b0);
    expect_word("u", 32'hABCD_E0B7, 1'b0, 1'b1);
    req(JTYPE, 32'h000F_FFFE, 32'h0000_006F, 1'b0);
    expect_word("j_max", 32'h7FFF_F06F, 1'b0, 1'b1);
    req(ITYPE, 32'hFFFF_F800, 32'h0000_0013, 1'b0);
    expect_word("i_min", 32'h8000_0013, 1'b0, 1'b1);
    req(ITYPE, 32'h0000_07FF, 32'h0000_0013, 1'b0);
    expect_word("i_max", 32'h7FF0_0013, 1'b0, 1'b1);

    // Range errors: word still emitted with truncated fields.
    req(BTYPE, 32'h0000_0003, 32'h0000_0063, 1'b0);
    expect_word("b_odd", 32'h0000_0163, 1'b1, 1'b1);
    req(JTYPE, 32'h0010_0000, 32'h0000_006F, 1'b0);
    expect_word("j_range", 32'h8000_006F, 1'b1, 1'b1);
    req(ITYPE, 32'h0000_0800, 32'h0000_0093, 1'b0);
    expect_word("i_range", 32'h8000_0093, 1'b1, 1'b1);
    req(UTYPE, 32'h0000_1001, 32'h0000_0037, 1'b0);
    expect_word("u_low", 32'h0000_1037, 1'b1, 1'b1);
    req(3'b111, 32'h1234_5678, 32'h0000_0033, 1'b0);
    expect_word("bad_type", 32'h0000_0033, 1'b1, 1'b1);

    // In-range I with split permitted stays a single word.
    req(ITYPE, 32'h0000_0005, 32'h0000_0093, 1'b1);
    expect_word("split_inrange", 32'h0050_0093, 1'b0, 1'b1);

    // Split: LUI then ADDI, in_ready low while LUI is held.
    req(ITYPE, 32'h1234_5FFF, 32'h0000_0293, 1'b1);
    expect_word("split_hi", 32'h1234_62B7, 1'b0, 1'b0);
    check("split_hi.ready", {31'b0, in_ready}, 32'd0);
    step();
    expect_word("split_lo", 32'hFFF2_8293, 1'b0, 1'b1);
    step();
    check("split_done.valid", {31'b0, out_valid}, 32'd0);

    // Back-to-back stream of four requests, one word per cycle.
    for (int i = 0; i < 4; i++) begin
      drive(ITYPE, 32'(i + 1), 32'h0000_0013, 1'b0);
      step();
      expect_word($sformatf("stream%0d", i), (32'(i + 1) << 20) | 32'h13, 1'b0, 1'b1);
    end
    in_valid = 1'b0;
    step();
    check("stream_end.valid", {31'b0, out_valid}, 32'd0);

    // Backpressure: word stable and in_ready low for three cycles.
    out_ready = 1'b0;
    req(STYPE, 32'hFFFF_F800, 32'h0000_2023, 1'b0);
    held = 32'h8000_2023;
    for (int i = 0; i < 3; i++) begin
      drive(ITYPE, 32'h0000_0001, 32'h0000_0013, 1'b0);
      expect_word($sformatf("stall%0d", i), held, 1'b0, 1'b1);
      check($sformatf("stall%0d.ready", i), {31'b0, in_ready}, 32'd0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    expect_word("stall_release", held, 1'b0, 1'b1);
    step();
    check("stall_drained.valid", {31'b0, out_valid}, 32'd0);

    // Reset while the LUI is held: word 2 is discarded.
    out_ready = 1'b0;
    req(ITYPE, 32'h0001_0000, 32'h0000_0513, 1'b1);
    expect_word("rst_split_hi", 32'h0001_0537, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    check("rst_split.valid", {31'b0, out_valid}, 32'd0);
    check("rst_split.ready", {31'b0, in_ready}, 32'd1);
    step();
    check("rst_split_quiet.valid", {31'b0, out_valid}, 32'd0);
    req(ITYPE, 32'h0000_0005, 32'h0000_0093, 1'b0);
    expect_word("post_rst", 32'h0050_0093, 1'b0, 1'b1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
